uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver, the receive-side counterpart of `uart_tx`. It recovers 8N1-style frames from an asynchronous serial line: start bit, `DATA_BITS` data bits LSB first, optional even parity bit, one stop bit. It synchronises the line, detects the start edge, samples each bit at its nominal centre, and presents each completed word with a one-cycle valid strobe. It sits at the chip's serial input pin and feeds the downstream consumer logic.

## Interface
- `CLK_FREQUENCY`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line baud rate.
- `DATA_BITS`, default 7: data bits per frame.
- Derived localparam `baud_divider = CLK_FREQUENCY/BAUD_RATE`, using integer division (434 at defaults). `half_divider = baud_divider/2` (217).
- Clocking and reset (already decided): one clock; reset is synchronous and active-high. The ports are `clk` and `reset`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `received_bit`  in  1  asynchronous serial line; idles high.
- `received_data`  out  DATA_BITS  last correctly received word.
- `data_valid`  out  1  one-cycle pulse when `received_data` updates.
- `framing_error`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parity_error`  out  1  one-cycle pulse on a parity mismatch. Constant 0 when parity is compiled out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `received_bit` passes through a 2-flop synchroniser (`rx_sync`). The synchroniser flops reset to 1.
- A cycle counter runs 0..`baud_divider`-1. A bit index runs 0..`DATA_BITS`-1. A shift register is `DATA_BITS` wide.
- State machine: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_HIGH.
- **IDLE**
  - When `rx_sync`==0, go to START and clear the counter.
- **START**
  - At count `half_divider`-1, sample `rx_sync`.
  - If it is 0, go to DATA and clear the counter and index.
  - If it is 1 (glitch), go to IDLE with no output pulse.
- **DATA**
  - At count `baud_divider`-1, sample `rx_sync` and shift it into the MSB of the shift register. After `DATA_BITS` shifts, bit 0 holds the first bit received.
  - After the last bit, go to PARITY if enabled, otherwise STOP.
- **PARITY**
  - At count `baud_divider`-1, sample `rx_sync` and compare it with the even parity of the shift register. Store the mismatch flag, then go to STOP.
- **STOP**
  - At count `baud_divider`-1, sample `rx_sync`.
  - Sample 1 with no parity mismatch: load `received_data`, pulse `data_valid`, go to IDLE.
  - Sample 1 with a parity mismatch: pulse `parity_error`; `received_data` is unchanged; go to IDLE.
  - Sample 0: pulse `framing_error` only, with no `parity_error` pulse even if parity also mismatched. `received_data` is unchanged. Go to WAIT_HIGH.
- **WAIT_HIGH** (break or line-held-low case)
  - Stay until `rx_sync`==1, then go to IDLE. No new start is detected while the line stays low.
- All outputs are registered.

## Timing
- Reset value of every output is 0: `received_data`, `data_valid`, `framing_error`, `parity_error`, `busy`.
- Reset also forces IDLE and clears the counter, index, shift register and parity flag.
- Reset asserted mid-frame aborts the frame with no pulse.
- Let T be the IDLE cycle in which `rx_sync`==0 is seen. Sample edges:
  - start bit: T+`half_divider`
  - data bit i: T+`half_divider`+(i+1)·`baud_divider`
  - parity bit: T+`half_divider`+(`DATA_BITS`+1)·`baud_divider`
  - stop bit: one `baud_divider` after the last data bit, or after the parity bit when enabled.
- Line-to-T latency is 2–3 cycles (synchroniser).
- Result pulses are registered on the stop-sample edge: high for exactly the following cycle.
- `busy` falls on the same edge the pulses rise.
- The return to IDLE happens at mid-stop-bit, so a start bit immediately after the stop bit (back-to-back frames) is detected.
- A glitch shorter than `half_divider` cycles is rejected.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** the frame carries one even-parity bit between the data bits and the stop bit, and PARITY state and `parity_error` are active. On a mismatch, `data_valid` does not pulse and `received_data` is unchanged.
- **Undefined:** there is no PARITY state, frame length is `DATA_BITS`+2 bits, and `parity_error` is tied to 0.

## Test plan
All scenarios use the defaults (divider 434, `DATA_BITS`=7). Bits are driven for 434 cycles each.
1. Frame with data 7'b1010011, stop=1 -> `received_data`=7'h53, `data_valid` high exactly 1 cycle, no error pulses, `busy` low afterwards.
2. Line pulled low for 100 cycles, then high -> no pulses; `busy` rises then returns to 0 within 220 cycles; `received_data` unchanged.
3. Frame 7'h2A with stop bit driven 0, line held low 2000 cycles, then frame 7'h11 -> one `framing_error` pulse, no `data_valid` for 7'h2A, no start detected while low, then `data_valid` with 7'h11.
4. `reset` asserted 1 cycle during data bit 3 of 7'h7F -> all outputs 0 next cycle; a following frame 7'h05 gives `received_data`=7'h05.
5. Back-to-back frames 7'h00 then 7'h7F with zero idle gap -> two `data_valid` pulses 3906 ±3 cycles apart, values 7'h00 and 7'h7F.
6. With `UART_RX_PARITY_EN`: frame 7'h03 with parity bit 1 (wrong) -> `parity_error` pulse, no `data_valid`. The same frame with parity 0 -> `data_valid`, `received_data`=7'h03.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, start-edge detect, centre sampling, registered result pulses.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 received_bit,
  output logic [DATA_BITS-1:0] received_data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int baud_divider = CLK_FREQUENCY / BAUD_RATE;
  localparam int half_divider = baud_divider / 2;
  localparam int CW = (baud_divider > 1) ? $clog2(baud_divider) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(baud_divider - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(half_divider - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  logic [1:0]           sync;
  logic                 rx_sync;
  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [CW-1:0]        count;
  logic [IW-1:0]        index;
  logic [DATA_BITS-1:0] shift;
  logic                 count_clear;

  assign rx_sync = sync[1];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rx_sync) state_next = START;
      START:     if (count == HALF_LAST) state_next = rx_sync ? IDLE : DATA;
      DATA:
        if (count == BAUD_LAST && index == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (count == BAUD_LAST) state_next = STOP;
`endif
      STOP:      if (count == BAUD_LAST) state_next = rx_sync ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_sync) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The counter restarts on every state change and on each bit period within DATA.
  assign count_clear = (state == IDLE) || (state_next != state) || (count == BAUD_LAST);

`ifdef UART_RX_PARITY_EN
  logic parity_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bad   <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      if (state == PARITY && count == BAUD_LAST)
        parity_bad <= rx_sync ^ (^shift);
      if (state == STOP && count == BAUD_LAST && rx_sync && parity_bad)
        parity_error <= 1'b1;
    end
  end
`else
  logic parity_bad;
  assign parity_bad   = 1'b0;
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync          <= '1;
      state         <= IDLE;
      count         <= '0;
      index         <= '0;
      shift         <= '0;
      received_data <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      sync          <= {sync[0], received_bit};
      state         <= state_next;
      busy          <= (state_next != IDLE);
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      count         <= count_clear ? '0 : count + CW'(1);

      case (state)
        START: index <= '0;
        DATA:
          if (count == BAUD_LAST) begin
            shift <= {rx_sync, shift[DATA_BITS-1:1]};
            index <= (index == IDX_LAST) ? '0 : index + IW'(1);
          end
        STOP:
          if (count == BAUD_LAST) begin
            if (!rx_sync) begin
              framing_error <= 1'b1;
            end else if (!parity_bad) begin
              received_data <= shift;
              data_valid    <= 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomised frame bench for uart_rx with a frame-level reference model.
module tb_uart_rx;

  localparam int DB   = 7;
  localparam int BAUD = 50_000_000 / 115_200;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          received_bit;
  logic [DB-1:0] received_data;
  logic          data_valid;
  logic          framing_error;
  logic          parity_error;
  logic          busy;

  uart_rx #(
    .CLK_FREQUENCY(50_000_000),
    .BAUD_RATE    (115_200),
    .DATA_BITS    (DB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .received_bit (received_bit),
    .received_data(received_data),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .parity_error (parity_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Observed events
  int            cyc = 0;
  int            dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, long_cnt = 0;
  int            dv_t = 0, dv_prev_t = 0;
  logic [DB-1:0] dv_val = '0, dv_prev_val = '0;
  logic          p_dv = 1'b0, p_fe = 1'b0, p_pe = 1'b0;
  logic          busy_seen = 1'b0;

  // Reference model state
  int            exp_dv = 0, exp_fe = 0, exp_pe = 0;
  logic [DB-1:0] exp_data = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_cnt++;
      dv_prev_val = dv_val;
      dv_val      = received_data;
      dv_prev_t   = dv_t;
      dv_t        = cyc;
    end
    if (framing_error === 1'b1) fe_cnt++;
    if (parity_error === 1'b1) pe_cnt++;
    if ((data_valid === 1'b1 && p_dv) || (framing_error === 1'b1 && p_fe) ||
        (parity_error === 1'b1 && p_pe))
      long_cnt++;
    p_dv = (data_valid === 1'b1);
    p_fe = (framing_error === 1'b1);
    p_pe = (parity_error === 1'b1);
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level outcome: stop low wins, then parity, else a new word.
  task automatic model_frame(input logic [DB-1:0] d, input logic stop, input logic par);
    if (!stop) exp_fe++;
    else if (PB != 0 && par != ^d) exp_pe++;
    else begin
      exp_dv++;
      exp_data = d;
    end
  endtask

  task automatic send_bit(input logic b);
    received_bit = b;
    repeat (BAUD) @(posedge clk);
  endtask

  task automatic send_body(input logic [DB-1:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (PB != 0) send_bit(par);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par);
    send_body(d, par);
    send_bit(stop);
    received_bit = 1'b1;
    model_frame(d, stop, par);
  endtask

  task automatic check_frame(input string tag);
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_dv"},   dv_cnt, exp_dv);
    check({tag, "_fe"},   fe_cnt, exp_fe);
    check({tag, "_pe"},   pe_cnt, exp_pe);
    check({tag, "_data"}, received_data, exp_data);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_wide"}, long_cnt, 0);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          stop, par;
    int            gap;

    reset = 1'b1;
    received_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", received_data, '0);
    check("rst_dv",   data_valid, 1'b0);
    check("rst_fe",   framing_error, 1'b0);
    check("rst_pe",   parity_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // Plain frame
    send_frame(7'h53, 1'b1, ^7'h53);
    check_frame("f53");

    // Short low pulse is a rejected glitch
    busy_seen = 1'b0;
    received_bit = 1'b0;
    repeat (100) @(posedge clk);
    received_bit = 1'b1;
    repeat (220) @(posedge clk);
    #1;
    check("glitch_busy_seen", busy_seen, 1'b1);
    check_frame("glitch");

    // Stop bit low, line held low, then a good frame
    send_body(7'h2A, ^7'h2A);
    received_bit = 1'b0;
    repeat (BAUD + 1000) @(posedge clk);
    #1;
    model_frame(7'h2A, 1'b0, ^7'h2A);
    check("brk_fe",   fe_cnt, exp_fe);
    check("brk_busy", busy, 1'b1);
    repeat (1000) @(posedge clk);
    #1;
    check("brk_nostart_dv", dv_cnt, exp_dv);
    check("brk_nostart_fe", fe_cnt, exp_fe);
    received_bit = 1'b1;
    check_frame("brk");
    send_frame(7'h11, 1'b1, ^7'h11);
    check_frame("f11");

    // Reset in the middle of data bit 3
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    repeat (200) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_data = '0;
    check("mid_rst_data", received_data, '0);
    check("mid_rst_dv",   data_valid, 1'b0);
    check("mid_rst_fe",   framing_error, 1'b0);
    check("mid_rst_pe",   parity_error, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (BAUD * (DB + PB)) @(posedge clk);
    check_frame("abort");
    send_frame(7'h05, 1'b1, ^7'h05);
    check_frame("f05");

    // Back-to-back frames with no idle gap
    send_frame(7'h00, 1'b1, 1'b0);
    send_frame(7'h7F, 1'b1, ^7'h7F);
    check_frame("b2b");
    check("b2b_first", dv_prev_val, 7'h00);
    gap = dv_t - dv_prev_t;
    check("b2b_gap", (gap >= (DB + 2 + PB) * BAUD - 3) && (gap <= (DB + 2 + PB) * BAUD + 3), 1'b1);

`ifdef UART_RX_PARITY_EN
    send_frame(7'h03, 1'b1, 1'b1);
    check_frame("par_bad");
    send_frame(7'h03, 1'b1, 1'b0);
    check_frame("par_ok");
`endif

    // Randomised frames: data, occasional bad stop, occasional bad parity
    for (int k = 0; k < 6; k++) begin
      d    = DB'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = (^d) ^ ((PB != 0) && ($urandom_range(0, 3) == 0));
      send_frame(d, stop, par);
      check_frame("rnd");
      repeat ($urandom_range(0, 50)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
